rr_arbiter_8: RTL and testbench

- Round-robin arbiter sharing one resource among 8 requesters; the grant decision is built on a masked 8-to-3 MSB-first priority encode.
- Sits in front of any single-ported shared datapath. Grants one requester at a time and holds the grant until that requester releases it.
- Produces a one-hot grant vector plus a binary grant index for downstream muxing.

---
 rtl/arb_pkg.sv | 11 +
 rtl/rr_pick.sv | 18 +
 rtl/rr_arbiter_8.sv | 60 ++++++
 tb/tb_rr_arbiter_8.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, state encoding and MSB-first priority encoder for rr_arbiter_8
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W = 3;
  localparam int DEF_MAX_HOLD = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  function automatic logic [ID_W-1:0] msb_idx(input logic [N_REQ-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < N_REQ; i++) if (v[i]) msb_idx = ID_W'(i);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner select, masked MSB-first encode falling back to unmasked
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  win_id,
  output logic             win_vld
);
  logic [N_REQ-1:0] mask, masked;
  // bits strictly below the last grant get priority, descending with wrap 0->7
  always_comb begin
    mask = (N_REQ'(1) << ptr) - N_REQ'(1);
    masked = req & mask;
    win_id = |masked ? msb_idx(masked) : msb_idx(req);
    win_vld = |req;
  end
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with grant hold; optional forced release under ARB_TIMEOUT_EN
module rr_arbiter_8
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);
  state_t state;
  logic [ID_W-1:0] ptr, win_id;
  logic win_vld, tmo, rel, arb;
  logic [N_REQ-1:0] pick_req;
  rr_pick u_pick (.req(pick_req), .ptr(ptr), .win_id(win_id), .win_vld(win_vld));
  // the releasing holder is excluded so it goes to the back of the rotation
  always_comb begin
    rel = (state == ST_GRANT) && (done || !req[gnt_id] || tmo);
    arb = (state == ST_IDLE) || rel;
    pick_req = req & ~gnt;
  end
`ifdef ARB_TIMEOUT_EN
  localparam int MAX_HOLD = DEF_MAX_HOLD;
  localparam int CNT_W = $clog2(MAX_HOLD);
  logic [CNT_W-1:0] hold_cnt;
  assign tmo = (state == ST_GRANT) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
  // tenure counter restarts on every arbitration and times out the holder
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      hold_cnt <= arb ? '0 : hold_cnt + CNT_W'(1);
      timeout <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign timeout = 1'b0;
`endif
  // grant FSM: arbitrate from IDLE or on release, otherwise hold the grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_valid <= 1'b0;
      ptr <= ID_W'(N_REQ - 1);
    end else if (arb) begin
      state <= win_vld ? ST_GRANT : ST_IDLE;
      gnt <= win_vld ? N_REQ'(1) << win_id : '0;
      gnt_id <= win_vld ? win_id : '0;
      gnt_valid <= win_vld;
      ptr <= win_vld ? win_id : ptr;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed self-checking bench for rr_arbiter_8 (timeout scenario under ARB_TIMEOUT_EN)
module tb_rr_arbiter_8;
  logic clk = 1'b0, rst = 1'b0, done = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic gnt_valid, timeout;
  int checks = 0, errors = 0;
  rr_arbiter_8 dut (.clk(clk), .rst(rst), .req(req), .done(done), .gnt(gnt),
    .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1; req = '0; done = 1'b0;
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== 13'd0) begin
      errors++;
      $display("FAIL reset: gnt=%b id=%0d vld=%b to=%b, want all 0", gnt, gnt_id, gnt_valid, timeout);
    end
  endtask
  task automatic test_single();
    do_reset();
    req = 8'b00000001;
    step();
    checks++;
    if (gnt !== 8'b00000001 || gnt_id !== 3'd0 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL single: gnt=%b id=%0d vld=%b, want 00000001 0 1", gnt, gnt_id, gnt_valid);
    end
  endtask
  task automatic test_rotation();
    logic [2:0] exp_ids [5] = '{3'd6, 3'd5, 3'd2, 3'd7, 3'd6};
    do_reset();
    req = 8'b11100100;
    step();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (gnt_id !== exp_ids[k] || gnt !== (8'd1 << exp_ids[k]) || gnt_valid !== 1'b1) begin
        errors++;
        $display("FAIL rotation[%0d]: gnt=%b id=%0d, want id=%0d", k, gnt, gnt_id, exp_ids[k]);
      end
      done = 1'b1;
      step();
      done = 1'b0;
    end
  endtask
  task automatic test_withdraw();
    do_reset();
    req = 8'b00001000;
    step();
    checks++;
    if (gnt_id !== 3'd3 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL withdraw_grant: id=%0d vld=%b, want 3 1", gnt_id, gnt_valid);
    end
    req = '0;
    step();
    checks++;
    if (gnt !== 8'd0 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_idle: gnt=%b vld=%b, want 0 0", gnt, gnt_valid);
    end
    req = 8'b00001000;
    step();
    checks++;
    if (gnt !== 8'b00001000 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL withdraw_regrant: gnt=%b vld=%b, want 00001000 1", gnt, gnt_valid);
    end
  endtask
  task automatic test_no_bubble();
    do_reset();
    req = 8'b00001100;
    step();
    req = 8'b00000100;
    step();
    checks++;
    if (gnt !== 8'b00000100 || gnt_id !== 3'd2 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL no_bubble: gnt=%b id=%0d vld=%b, want 00000100 2 1", gnt, gnt_id, gnt_valid);
    end
  endtask
  task automatic test_hold();
    int bad = 0;
    do_reset();
    req = 8'b00010000;
    step();
    req = 8'b10010001;
    for (int k = 0; k < 20; k++) begin
      step();
`ifdef ARB_TIMEOUT_EN
      if (k >= 14) break;
`endif
      checks++;
      if (gnt !== 8'b00010000 || gnt_id !== 3'd4 || timeout !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 4) $display("FAIL hold[%0d]: gnt=%b to=%b, want 00010000 0", k, gnt, timeout);
      end
    end
  endtask
  task automatic test_mid_reset();
    do_reset();
    req = 8'b00100000;
    step();
    checks++;
    if (gnt_id !== 3'd5) begin
      errors++;
      $display("FAIL mid_reset_grant: id=%0d, want 5", gnt_id);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: gnt=%b id=%0d vld=%b to=%b, want all 0", gnt, gnt_id, gnt_valid, timeout);
    end
    req = 8'b10000001;
    step();
    checks++;
    if (gnt_id !== 3'd0 || gnt !== 8'b00000001) begin
      errors++;
      $display("FAIL mid_reset_ptr: gnt=%b id=%0d, want 00000001 0", gnt, gnt_id);
    end
  endtask
`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 8'b00100010;
    step();
    for (int k = 1; k < 16; k++) begin
      checks++;
      if (gnt_id !== 3'd5 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_hold[%0d]: id=%0d to=%b, want 5 0", k, gnt_id, timeout);
      end
      step();
    end
    checks++;
    if (gnt_id !== 3'd5 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_last: id=%0d to=%b, want 5 0", gnt_id, timeout);
    end
    step();
    checks++;
    if (gnt_id !== 3'd1 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: id=%0d to=%b, want 1 1", gnt_id, timeout);
    end
    step();
    checks++;
    if (gnt_id !== 3'd1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: id=%0d to=%b, want 1 0", gnt_id, timeout);
    end
  endtask
`endif
  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_rotation();
    test_withdraw();
    test_no_bubble();
    test_hold();
    test_mid_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
